// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with latency-matched sync/blank/RGB outputs
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIPE_DLY = 2,
  parameter int   CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [23:0]      rgb_in,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start,
  output logic             VGA_CLK,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             VGA_SYNC_N,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // {hs, vs, active} with both syncs deasserted and the beam blanked
  localparam logic [2:0] IDLE_BITS = {~HS_POL, ~VS_POL, 1'b0};

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             hs0;
  logic             vs0;
  logic [2:0]       stage0;
  logic [2:0]       dly_out;

  // Reset gates the tick so nothing downstream moves while reset is held
  assign pix_tick    = (div == DIV_LAST) && !reset;
  // Rising edge lands mid-pixel so the DAC latches settled data
  assign VGA_CLK     = (div >= DIV_HALF);
  assign VGA_SYNC_N  = 1'b0;

  assign x           = hcnt;
  assign y           = vcnt;
  assign active      = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs0         = ((hcnt >= HS_BEG) && (hcnt <= HS_LAST)) ? HS_POL : ~HS_POL;
  assign vs0         = ((vcnt >= VS_BEG) && (vcnt <= VS_LAST)) ? VS_POL : ~VS_POL;
  assign line_start  = pix_tick && (hcnt == '0);
  assign frame_start = line_start && (vcnt == '0);
  assign stage0      = {hs0, vs0, active};

  // Pixel clock divider: counts 0..CLK_DIV-1 and wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Beam position counters, advancing once per pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        if (vcnt == V_LAST) begin
          vcnt <= '0;
        end else begin
          vcnt <= vcnt + 1'b1;
        end
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_direct
      assign dly_out = stage0;
    end else begin : g_pipe
      logic [2:0] pipe [PIPE_DLY];

      // Sync/blank delay line matching the renderer's RGB latency
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            pipe[i] <= IDLE_BITS;
          end
        end else if (pix_tick) begin
          pipe[0] <= stage0;
          for (int i = 1; i < PIPE_DLY; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign dly_out = pipe[PIPE_DLY-1];
    end
  endgenerate

  // Pin register: syncs, blank and RGB change together once per pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
    end else if (pix_tick) begin
      VGA_HS      <= dly_out[2];
      VGA_VS      <= dly_out[1];
      VGA_BLANK_N <= dly_out[0];
      if (dly_out[0]) begin
        {VGA_R, VGA_G, VGA_B} <= rgb_in;
      end else begin
        {VGA_R, VGA_G, VGA_B} <= 24'h000000;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // a: default mode, b: small mode, c: inverted polarity with short frame
  logic        reset_a, reset_b, reset_c;
  logic [23:0] rgb_a, rgb_b, rgb_c;
  logic [9:0]  x_a, y_a, x_b, y_b, x_c, y_c;
  logic        act_a, tick_a, ls_a, fs_a, vclk_a, hs_a, vs_a, bn_a, sn_a;
  logic        act_b, tick_b, ls_b, fs_b, vclk_b, hs_b, vs_b, bn_b, sn_b;
  logic        act_c, tick_c, ls_c, fs_c, vclk_c, hs_c, vs_c, bn_c, sn_c;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  vga_timing_gen dut_a (
    .clk(clk), .reset(reset_a), .rgb_in(rgb_a), .x(x_a), .y(y_a), .active(act_a),
    .pix_tick(tick_a), .line_start(ls_a), .frame_start(fs_a), .VGA_CLK(vclk_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(3), .PIPE_DLY(0)
  ) dut_b (
    .clk(clk), .reset(reset_b), .rgb_in(rgb_b), .x(x_b), .y(y_b), .active(act_b),
    .pix_tick(tick_b), .line_start(ls_b), .frame_start(fs_b), .VGA_CLK(vclk_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
  );

  vga_timing_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_c (
    .clk(clk), .reset(reset_c), .rgb_in(rgb_c), .x(x_c), .y(y_c), .active(act_c),
    .pix_tick(tick_c), .line_start(ls_c), .frame_start(fs_c), .VGA_CLK(vclk_c),
    .VGA_HS(hs_c), .VGA_VS(vs_c), .VGA_BLANK_N(bn_c), .VGA_SYNC_N(sn_c),
    .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c)
  );

  task automatic test_reset;
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    rgb_a = 24'h123456; rgb_b = 24'hFF8040; rgb_c = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (x_a !== 10'd0 || y_a !== 10'd0) $display("FAIL reset_xy got %0d,%0d want 0,0", x_a, y_a); else pass_cnt++;
    total_cnt++; if ({tick_a, ls_a, fs_a} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {tick_a, ls_a, fs_a}); else pass_cnt++;
    total_cnt++; if ({hs_a, vs_a, bn_a, sn_a} !== 4'b1100) $display("FAIL reset_pins got %b want 1100", {hs_a, vs_a, bn_a, sn_a}); else pass_cnt++;
    total_cnt++; if ({r_a, g_a, b_a} !== 24'h0) $display("FAIL reset_rgb got %h want 000000", {r_a, g_a, b_a}); else pass_cnt++;
    total_cnt++; if ({hs_c, vs_c, bn_c} !== 3'b000) $display("FAIL reset_pol_pins got %b want 000", {hs_c, vs_c, bn_c}); else pass_cnt++;
    total_cnt++; if (tick_b !== 1'b0) $display("FAIL reset_small_tick got %b want 0", tick_b); else pass_cnt++;
  endtask

  task automatic test_default_timing;
    int j, p, hx, vy, hs_low, hs_fall;
    logic et;
    logic [2:0] q[$];
    logic [2:0] e;
    logic [23:0] trgb, ergb;
    j = 0; et = 1'b0; hs_low = 0; hs_fall = -1; trgb = 24'h0;
    @(negedge clk);
    reset_a = 1'b0;
    repeat (6200) begin
      @(posedge clk);
      #1;
      j++;
      p = j / 2; hx = p % 800; vy = (p / 800) % 525;
      et = (j % 2 == 1);
      total_cnt++; if (tick_a !== et) $display("FAIL def_tick j=%0d got %b want %b", j, tick_a, et); else pass_cnt++;
      total_cnt++; if (vclk_a !== et) $display("FAIL def_vga_clk j=%0d got %b want %b", j, vclk_a, et); else pass_cnt++;
      total_cnt++; if (x_a !== hx[9:0] || y_a !== vy[9:0]) $display("FAIL def_xy j=%0d got %0d,%0d want %0d,%0d", j, x_a, y_a, hx, vy); else pass_cnt++;
      total_cnt++; if (act_a !== (hx < 640 && vy < 480)) $display("FAIL def_active j=%0d got %b", j, act_a); else pass_cnt++;
      total_cnt++; if (ls_a !== (et && hx == 0)) $display("FAIL def_line_start j=%0d got %b", j, ls_a); else pass_cnt++;
      total_cnt++; if (fs_a !== (et && hx == 0 && vy == 0)) $display("FAIL def_frame_start j=%0d got %b", j, fs_a); else pass_cnt++;
      if (!et && q.size() > 2) begin
        e = q.pop_front();
        ergb = e[0] ? trgb : 24'h0;
        total_cnt++; if ({hs_a, vs_a, bn_a} !== e) $display("FAIL def_pins j=%0d got %b want %b", j, {hs_a, vs_a, bn_a}, e); else pass_cnt++;
        total_cnt++; if ({r_a, g_a, b_a} !== ergb) $display("FAIL def_rgb j=%0d got %h want %h", j, {r_a, g_a, b_a}, ergb); else pass_cnt++;
      end
      if (et) q.push_back({!(hx >= 656 && hx <= 751), !(vy >= 490 && vy <= 491), (hx < 640 && vy < 480)});
      if (et && p < 800 && hs_a == 1'b0) hs_low++;
      if (hs_fall < 0 && hs_a == 1'b0) hs_fall = p;
      @(negedge clk);
      rgb_a = 24'($urandom());
      if (et) trgb = rgb_a;
    end
    total_cnt++; if (hs_low != 96) $display("FAIL def_hsync_width got %0d want 96", hs_low); else pass_cnt++;
    total_cnt++; if (hs_fall != 659) $display("FAIL def_hsync_start got slot %0d want 659", hs_fall); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    logic found;
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (x_a == 10'd300 && tick_a == 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++; if (!found) $display("FAIL midrst_find got timeout want x=300 tick"); else pass_cnt++;
    reset_a = 1'b1;
    #1;
    total_cnt++; if ({tick_a, ls_a, fs_a} !== 3'b000) $display("FAIL midrst_gate got %b want 000", {tick_a, ls_a, fs_a}); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (x_a !== 10'd0 || y_a !== 10'd0) $display("FAIL midrst_xy got %0d,%0d want 0,0", x_a, y_a); else pass_cnt++;
    total_cnt++; if ({hs_a, vs_a, bn_a, tick_a} !== 4'b1100) $display("FAIL midrst_pins got %b want 1100", {hs_a, vs_a, bn_a, tick_a}); else pass_cnt++;
    total_cnt++; if ({r_a, g_a, b_a} !== 24'h0) $display("FAIL midrst_rgb got %h want 000000", {r_a, g_a, b_a}); else pass_cnt++;
    @(negedge clk);
    reset_a = 1'b0;
    #1;
    total_cnt++; if (tick_a !== 1'b0) $display("FAIL midrst_early_tick got %b want 0", tick_a); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if ({tick_a, fs_a, ls_a} !== 3'b111 || x_a !== 10'd0) $display("FAIL midrst_first_frame got %b x=%0d want 111 x=0", {tick_a, fs_a, ls_a}, x_a); else pass_cnt++;
  endtask

  task automatic test_small_mode;
    int j, p, hx, vy, pidx, bn_cnt, fs_last, ls_last, fs_per, ls_per;
    logic et;
    logic [2:0] q[$];
    logic [2:0] e;
    logic [23:0] ergb;
    j = 0; et = 1'b0; pidx = 0; bn_cnt = 0;
    fs_last = -1; ls_last = -1; fs_per = 0; ls_per = 0;
    @(negedge clk);
    reset_b = 1'b0;
    repeat (378) begin
      @(posedge clk);
      #1;
      j++;
      p = j / 3; hx = p % 7; vy = (p / 7) % 6;
      et = (j % 3 == 2);
      total_cnt++; if (tick_b !== et || vclk_b !== (j % 3 >= 1)) $display("FAIL small_tick j=%0d got %b%b", j, tick_b, vclk_b); else pass_cnt++;
      total_cnt++; if (x_b !== hx[9:0] || y_b !== vy[9:0]) $display("FAIL small_xy j=%0d got %0d,%0d want %0d,%0d", j, x_b, y_b, hx, vy); else pass_cnt++;
      if (j % 3 == 0 && q.size() > 0) begin
        e = q.pop_front();
        ergb = e[0] ? 24'hFF8040 : 24'h0;
        total_cnt++; if ({hs_b, vs_b, bn_b} !== e) $display("FAIL small_pins j=%0d got %b want %b", j, {hs_b, vs_b, bn_b}, e); else pass_cnt++;
        total_cnt++; if ({r_b, g_b, b_b} !== ergb) $display("FAIL small_rgb j=%0d got %h want %h", j, {r_b, g_b, b_b}, ergb); else pass_cnt++;
        if (pidx < 84 && bn_b == 1'b1) bn_cnt++;
        pidx++;
      end
      if (et) q.push_back({hx != 5, vy != 4, (hx < 4 && vy < 3)});
      if (fs_b) begin
        if (fs_last >= 0) fs_per = j - fs_last;
        fs_last = j;
      end
      if (ls_b) begin
        if (ls_last >= 0) ls_per = j - ls_last;
        ls_last = j;
      end
      @(negedge clk);
    end
    total_cnt++; if (bn_cnt != 24) $display("FAIL small_active_count got %0d want 24", bn_cnt); else pass_cnt++;
    total_cnt++; if (fs_per != 126) $display("FAIL small_frame_period got %0d want 126", fs_per); else pass_cnt++;
    total_cnt++; if (ls_per != 21) $display("FAIL small_line_period got %0d want 21", ls_per); else pass_cnt++;
  endtask

  task automatic test_polarity;
    int j, p, hs_hi, hs_rise, vs_hi, vs_rise;
    j = 0; hs_hi = 0; hs_rise = -1; vs_hi = 0; vs_rise = -1;
    @(negedge clk);
    reset_c = 1'b0;
    repeat (13000) begin
      @(posedge clk);
      #1;
      j++;
      p = j / 2;
      if (j % 2 == 1) begin
        if (p < 800 && hs_c == 1'b1) hs_hi++;
        if (vs_c == 1'b1) vs_hi++;
      end
      if (hs_rise < 0 && hs_c == 1'b1) hs_rise = p;
      if (vs_rise < 0 && vs_c == 1'b1) vs_rise = p;
    end
    total_cnt++; if (hs_hi != 96) $display("FAIL pol_hsync_width got %0d want 96", hs_hi); else pass_cnt++;
    total_cnt++; if (hs_rise != 659) $display("FAIL pol_hsync_start got slot %0d want 659", hs_rise); else pass_cnt++;
    total_cnt++; if (vs_hi != 1600) $display("FAIL pol_vsync_width got %0d ticks want 1600", vs_hi); else pass_cnt++;
    total_cnt++; if (vs_rise != 4003) $display("FAIL pol_vsync_start got slot %0d want 4003", vs_rise); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_default_timing();
    test_mid_reset();
    test_small_mode();
    test_polarity();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
